mul_special_pipe: RTL and testbench

Pipelined, parametrised special-operand stage for the multiplier datapath. It classifies both operands, generates the IEEE-754 special result (NaN, Inf or signed zero) and the invalid-operation flag, and accumulates sticky and counted status. It sits ahead of the mantissa multiply array, with a 2-stage registered pipeline and valid/ready backpressure on both sides.

---
 rtl/mul_special_pipe.sv | 229 ++++++++++++++++++++++
 tb/tb_mul_special_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_special_pipe.sv
// mul_special_pipe
// ----------------
// Special-operand stage placed ahead of the mantissa multiply array.
// Stage 1 classifies both operands; stage 2 registers the IEEE-754
// special result (NaN / Inf / signed zero), the invalid-operation flag
// and the product sign. A sticky invalid flag and a saturating counter
// track results delivered with out_nv set.
//
// Optional build macro: MUL_NAN_PROP_EN
//   undefined : every NaN result is the canonical qNaN.
//   defined   : a NaN result carries the payload and sign of A if A is
//               NaN, otherwise of B, with the mantissa MSB forced to 1.
//               zero x inf with no NaN operand still gives canonical qNaN.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  input handshake for the operand pair
//   a, b                operands {sign, expo, mant}
//   out_valid, out_ready output handshake
//   out_a_cls/out_b_cls operand class: 0 zero, 1 sub, 2 normal, 3 inf,
//                       4 qNaN, 5 sNaN
//   out_special         result fully determined here
//   out_spec_val        special result (0 when out_special=0)
//   out_sign            a.sign ^ b.sign
//   out_nv              invalid-operation flag for this result
//   flag_nv, nv_cnt     sticky invalid flag, saturating invalid count
//   flag_clr            clears flag_nv and nv_cnt
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. valid never drops and its data never changes until the
// transfer happens. in_ready is combinational from out_ready so the two
// stages advance as one shift register when the consumer is ready.

module mul_special_pipe #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 8,
    localparam int W     = SIGN_W + EXPO_W + MANT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_a_cls,
    output logic [2:0]       out_b_cls,
    output logic             out_special,
    output logic [W-1:0]     out_spec_val,
    output logic             out_sign,
    output logic             out_nv,
    output logic             flag_nv,
    input  logic             flag_clr,
    output logic [CNT_W-1:0] nv_cnt
);

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    localparam logic [W-1:0] CANON_QNAN =
        {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    function automatic logic [2:0] classify(input logic [EXPO_W-1:0] expo,
                                            input logic [MANT_W-1:0] mant);
        logic [2:0] cls;
        if (expo == '0)
            cls = (mant == '0) ? CLS_ZERO : CLS_SUB;
        else if (expo != '1)
            cls = CLS_NORM;
        else if (mant == '0)
            cls = CLS_INF;
        else if (mant[MANT_W-1])
            cls = CLS_QNAN;
        else
            cls = CLS_SNAN;
        return cls;
    endfunction

    // Stage 1 registers
    logic       s1_v;
    logic [2:0] s1_a_cls;
    logic [2:0] s1_b_cls;
    logic       s1_sign;
`ifdef MUL_NAN_PROP_EN
    logic              s1_a_sign;
    logic              s1_b_sign;
    logic [MANT_W-2:0] s1_a_pay;
    logic [MANT_W-2:0] s1_b_pay;
`endif

    // Stage 2 registers drive the outputs directly
    logic         s2_v;
    logic [2:0]   s2_a_cls;
    logic [2:0]   s2_b_cls;
    logic         s2_special;
    logic [W-1:0] s2_spec_val;
    logic         s2_sign;
    logic         s2_nv;

    logic adv1;
    logic adv2;

    assign adv2     = !s2_v || out_ready;
    assign adv1     = !s1_v || adv2;
    assign in_ready = adv1;

    // Stage 2 combinational result from stage 1 contents
    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, zero_x_inf;
    logic         nx_special;
    logic [W-1:0] nx_spec_val;
    logic         nx_nv;
    logic [W-1:0] nan_val;

    assign a_nan  = (s1_a_cls == CLS_QNAN) || (s1_a_cls == CLS_SNAN);
    assign b_nan  = (s1_b_cls == CLS_QNAN) || (s1_b_cls == CLS_SNAN);
    assign a_inf  = (s1_a_cls == CLS_INF);
    assign b_inf  = (s1_b_cls == CLS_INF);
    assign a_zero = (s1_a_cls == CLS_ZERO);
    assign b_zero = (s1_b_cls == CLS_ZERO);
    assign zero_x_inf = (a_zero && b_inf) || (a_inf && b_zero);
    assign nx_nv = (s1_a_cls == CLS_SNAN) || (s1_b_cls == CLS_SNAN) || zero_x_inf;

`ifdef MUL_NAN_PROP_EN
    // Quiet the NaN operand's payload; A has precedence over B.
    always_comb begin
        nan_val = CANON_QNAN;
        if (a_nan)
            nan_val = {s1_a_sign, {EXPO_W{1'b1}}, 1'b1, s1_a_pay};
        else if (b_nan)
            nan_val = {s1_b_sign, {EXPO_W{1'b1}}, 1'b1, s1_b_pay};
    end
`else
    assign nan_val = CANON_QNAN;
`endif

    always_comb begin
        nx_special  = 1'b1;
        nx_spec_val = '0;
        if (a_nan || b_nan || zero_x_inf)
            nx_spec_val = nan_val;
        else if (a_inf || b_inf)
            nx_spec_val = {s1_sign, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
        else if (a_zero || b_zero)
            nx_spec_val = {s1_sign, {(W-1){1'b0}}};
        else
            nx_special = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_a_cls <= '0;
            s1_b_cls <= '0;
            s1_sign  <= 1'b0;
`ifdef MUL_NAN_PROP_EN
            s1_a_sign <= 1'b0;
            s1_b_sign <= 1'b0;
            s1_a_pay  <= '0;
            s1_b_pay  <= '0;
`endif
            s2_v        <= 1'b0;
            s2_a_cls    <= '0;
            s2_b_cls    <= '0;
            s2_special  <= 1'b0;
            s2_spec_val <= '0;
            s2_sign     <= 1'b0;
            s2_nv       <= 1'b0;
        end else begin
            if (adv1) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_a_cls <= classify(a[W-2 -: EXPO_W], a[MANT_W-1:0]);
                    s1_b_cls <= classify(b[W-2 -: EXPO_W], b[MANT_W-1:0]);
                    s1_sign  <= a[W-1] ^ b[W-1];
`ifdef MUL_NAN_PROP_EN
                    s1_a_sign <= a[W-1];
                    s1_b_sign <= b[W-1];
                    s1_a_pay  <= a[MANT_W-2:0];
                    s1_b_pay  <= b[MANT_W-2:0];
`endif
                end
            end
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_a_cls    <= s1_a_cls;
                    s2_b_cls    <= s1_b_cls;
                    s2_special  <= nx_special;
                    s2_spec_val <= nx_spec_val;
                    s2_sign     <= s1_sign;
                    s2_nv       <= nx_nv;
                end
            end
        end
    end

    // Status: a delivered invalid result beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_nv <= 1'b0;
            nv_cnt  <= '0;
        end else if (s2_v && out_ready && s2_nv) begin
            flag_nv <= 1'b1;
            if (flag_clr)
                nv_cnt <= CNT_W'(1);
            else if (nv_cnt != '1)
                nv_cnt <= nv_cnt + CNT_W'(1);
        end else if (flag_clr) begin
            flag_nv <= 1'b0;
            nv_cnt  <= '0;
        end
    end

    assign out_valid    = s2_v;
    assign out_a_cls    = s2_a_cls;
    assign out_b_cls    = s2_b_cls;
    assign out_special  = s2_special;
    assign out_spec_val = s2_spec_val;
    assign out_sign     = s2_sign;
    assign out_nv       = s2_nv;

endmodule

// File: tb/tb_mul_special_pipe.sv
// Testbench for mul_special_pipe (fp32 fields, 2-bit invalid counter).
module tb_mul_special_pipe;

    localparam int EXPO_W = 8;
    localparam int MANT_W = 23;
    localparam int CNT_W  = 2;
    localparam int W      = 1 + EXPO_W + MANT_W;
    localparam int EXP_W  = 3 + 3 + 1 + W + 1 + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       out_a_cls;
    logic [2:0]       out_b_cls;
    logic             out_special;
    logic [W-1:0]     out_spec_val;
    logic             out_sign;
    logic             out_nv;
    logic             flag_nv;
    logic             flag_clr = 1'b0;
    logic [CNT_W-1:0] nv_cnt;

    mul_special_pipe #(
        .SIGN_W(1), .EXPO_W(EXPO_W), .MANT_W(MANT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a_cls(out_a_cls), .out_b_cls(out_b_cls),
        .out_special(out_special), .out_spec_val(out_spec_val),
        .out_sign(out_sign), .out_nv(out_nv),
        .flag_nv(flag_nv), .flag_clr(flag_clr), .nv_cnt(nv_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EXP_W-1:0] exp_q[$];
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic model_flag = 1'b0;
    int   model_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_cls(input logic [W-1:0] x);
        logic [7:0]  e = x[30:23];
        logic [22:0] m = x[22:0];
        if (e == 8'h00) return (m == 0) ? 3'd0 : 3'd1;
        if (e != 8'hFF) return 3'd2;
        if (m == 0)     return 3'd3;
        return m[22] ? 3'd4 : 3'd5;
    endfunction

    function automatic logic [EXP_W-1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2:0]   ca = ref_cls(x);
        logic [2:0]   cb = ref_cls(y);
        logic         sign = x[31] ^ y[31];
        logic         x_nan = (ca >= 3'd4);
        logic         y_nan = (cb >= 3'd4);
        logic         zxi = (ca == 3'd0 && cb == 3'd3) || (ca == 3'd3 && cb == 3'd0);
        logic         nv = (ca == 3'd5) || (cb == 3'd5) || zxi;
        logic         special = 1'b1;
        logic [W-1:0] val;
        if (x_nan || y_nan || zxi) begin
            val = 32'h7FC00000;
`ifdef MUL_NAN_PROP_EN
            if (x_nan)      val = x | 32'h00400000;
            else if (y_nan) val = y | 32'h00400000;
`endif
        end else if (ca == 3'd3 || cb == 3'd3) begin
            val = {sign, 8'hFF, 23'h0};
        end else if (ca == 3'd0 || cb == 3'd0) begin
            val = {sign, 31'h0};
        end else begin
            special = 1'b0;
            val = '0;
        end
        return {ca, cb, special, val, sign, nv};
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic        s = 1'($urandom_range(0, 1));
        logic [22:0] m = 23'($urandom);
        case ($urandom_range(0, 6))
            0: return {s, 31'h0};
            1: return {s, 8'h00, (m == 0) ? 23'h1 : m};
            2: return {s, 8'($urandom_range(1, 254)), m};
            3: return {s, 8'hFF, 23'h0};
            4: return {s, 8'hFF, 1'b1, m[21:0]};
            5: return {s, 8'hFF, 1'b0, (m[21:0] == 0) ? 22'h1 : m[21:0]};
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks (start and end at a negedge) ----------------
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
        logic hs;
        bit   done = 0;
        a = va;
        b = vb;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            #4;
            hs = in_ready;
            @(posedge clk);
            if (hs) begin
                exp_q.push_back(ref_result(va, vb));
                done = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1 within 60 cycles");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] exp;
        logic [EXP_W-1:0] held = '0;
        logic             held_v = 1'b0;
        logic             nv_ev;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_q.delete();
                model_flag = 1'b0;
                model_cnt  = 0;
                held_v     = 1'b0;
            end else begin
                got = {out_a_cls, out_b_cls, out_special, out_spec_val, out_sign, out_nv};
                check("flag_nv", 64'(flag_nv), 64'(model_flag));
                check("nv_cnt", 64'(nv_cnt), 64'(model_cnt));
                if (held_v) begin
                    check("hold_valid", 64'(out_valid), 64'(1));
                    check("hold_data", 64'(got), 64'(held));
                end
                held_v = out_valid && !out_ready;
                held   = got;
                nv_ev  = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h expected no output", got);
                    end else begin
                        exp = exp_q.pop_front();
                        check("result", 64'(got), 64'(exp));
                        nv_ev = exp[0];
                    end
                end
                if (nv_ev) begin
                    model_flag = 1'b1;
                    model_cnt  = flag_clr ? 1 : ((model_cnt == CNT_MAX) ? CNT_MAX : model_cnt + 1);
                end else if (flag_clr) begin
                    model_flag = 1'b0;
                    model_cnt  = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] dir_a[8] = '{32'h7F800000, 32'hFF800000, 32'h80000000, 32'h7F800001,
                               32'h00000001, 32'h3F800000, 32'h00000000, 32'hFFC12345};
    logic [W-1:0] dir_b[8] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                               32'h3F800000, 32'hFFA00005, 32'hFF800000, 32'h7F800002};

    initial begin
        bit done;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_datapath", 64'({out_a_cls, out_b_cls, out_special, out_spec_val, out_sign, out_nv}), 64'(0));
        @(negedge clk);

        // directed operand pairs
        for (int i = 0; i < 8; i++) send(dir_a[i], dir_b[i]);
        wait_drain();

        // clear with no handshake, then saturate the counter
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h7F800001 + W'(i), 32'h3F800000);
        wait_drain();

        // sixth invalid result coincident with a clear
        send(32'h7F800010, 32'h40400000);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            #1;
            if (out_valid) begin
                flag_clr = 1'b1;
                @(negedge clk);
                flag_clr = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL clr_event_timeout: out_valid 0 expected 1");
        end
        wait_drain();

        // backpressure: fill both stages, in_ready must drop, data held
        ready_mode = 2;
        send(32'h3F800000, 32'h00000000);
        send(32'h7F800000, 32'hC0000000);
        fork
            send(32'h00000003, 32'h7FC00000);
            begin
                for (int i = 0; i < 3; i++) begin
                    #4;
                    check("in_ready_full", 64'(in_ready), 64'(0));
                    @(negedge clk);
                end
                ready_mode = 0;
            end
        join
        send(32'h80000000, 32'h80000000);
        wait_drain();

        // randomized traffic with random backpressure and clears
        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            send(rand_op(), rand_op());
            if ($urandom_range(0, 3) == 0) begin
                flag_clr = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                flag_clr = 1'b0;
            end
        end
        ready_mode = 0;
        wait_drain();

        // reset with both stages holding valid pairs
        ready_mode = 2;
        send(32'h7F800001, 32'h3F800000);
        send(32'h00000000, 32'hFF800000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        check("rst_mid_flag_nv", 64'(flag_nv), 64'(0));
        check("rst_mid_nv_cnt", 64'(nv_cnt), 64'(0));
        @(negedge clk);
        ready_mode = 0;
        repeat (10) @(negedge clk);

        // pipeline still works after the reset
        send(32'h00000000, 32'h7F800000);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
